// File: rtl/alpha_mem_req_arb_pkg.sv
// Shared types for the memory request arbiter: packet vector and source IDs.
`include "defines.vh"

package alpha_mem_req_arb_pkg;

  localparam int PKT_W = `PKT_W;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

endpackage

// File: rtl/alpha_mem_req_arb_if.sv
// Request-side bus between the I/D request sources, the arbiter and memory.
interface alpha_mem_req_arb_if
  import alpha_mem_req_arb_pkg::*;
#(
  parameter int CNT_W = 32
);

  pkt_t             i_req_pkt;
  logic             i_req_rdy;
  pkt_t             d_req_pkt;
  logic             d_req_rdy;
  pkt_t             mem_req_pkt_xx;
  logic             mem_req_ack_xx;
  logic [CNT_W-1:0] i_grant_cnt;
  logic [CNT_W-1:0] d_grant_cnt;

  modport slave (
    input  i_req_pkt, d_req_pkt, mem_req_ack_xx,
    output i_req_rdy, d_req_rdy, mem_req_pkt_xx, i_grant_cnt, d_grant_cnt
  );

  modport master (
    output i_req_pkt, d_req_pkt, mem_req_ack_xx,
    input  i_req_rdy, d_req_rdy, mem_req_pkt_xx, i_grant_cnt, d_grant_cnt
  );

endinterface

// File: rtl/alpha_pkt_fifo.sv
// Synchronous packet FIFO, DEPTH entries (power of two), no push-to-head bypass.
`include "defines.vh"

module alpha_pkt_fifo
  import alpha_mem_req_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  pkt_t                     push_pkt,
  input  logic                     pop,
  output pkt_t                     head_pkt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pkt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_pkt = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_pkt;
  end

endmodule

// File: rtl/defines.vh
// Request packet layout shared by the cache, arbiter and memory model.
`ifndef ALPHA_DEFINES_VH
`define ALPHA_DEFINES_VH

`define PKT_W           103
`define PKT_BITS        102:0
`define PKT_VLD         0
`define PKT_TYPE        2:1
`define PKT_SIZE        5:3
`define PKT_LAST        6
`define PKT_ADDR        38:7
`define PKT_DATA        102:39

`define PKT_TYPE_FETCH  2'd0
`define PKT_TYPE_LOAD   2'd1
`define PKT_TYPE_STORE  2'd2

`define OP_SZ_BYTE      3'd0
`define OP_SZ_HALF      3'd1
`define OP_SZ_WORD      3'd2
`define OP_SZ_LWRD      3'd3
`define REQ_SZ_LINE     3'd4

`endif

// File: rtl/alpha_mem_req_arb.sv
// Merges I-fetch and D-side requests into one memory request channel, round-robin.
// last_grant | meaning:  SRC_I = I won last grant, D wins next tie  |  SRC_D = I wins next tie
`include "defines.vh"

module alpha_mem_req_arb
  import alpha_mem_req_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  alpha_mem_req_arb_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  pkt_t             head_i, head_d, out_q;
  logic             full_i, full_d, empty_i, empty_d;
  logic [CW-1:0]    cnt_i, cnt_d;
  logic             live_q;
  logic             rdy_i, rdy_d, push_i, push_d;
  logic             load, grant_i, pop_i, pop_d;
  src_e             last_grant_q;
  logic [CNT_W-1:0] i_cnt_q, d_cnt_q;

  // live_q keeps both ready flags low until the first edge after reset release.
  assign rdy_i   = live_q & ~full_i;
  assign rdy_d   = live_q & ~full_d;
  assign push_i  = bus.i_req_pkt[`PKT_VLD] & rdy_i;
  assign push_d  = bus.d_req_pkt[`PKT_VLD] & rdy_d;

  assign load    = (~out_q[`PKT_VLD] | bus.mem_req_ack_xx) & (~empty_i | ~empty_d);
  assign grant_i = ~empty_i & (empty_d | (last_grant_q == SRC_D));
  assign pop_i   = load & grant_i;
  assign pop_d   = load & ~grant_i;

  alpha_pkt_fifo #(.DEPTH(DEPTH)) u_fifo_i (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_i),
    .push_pkt (bus.i_req_pkt),
    .pop      (pop_i),
    .head_pkt (head_i),
    .full     (full_i),
    .empty    (empty_i),
    .count    (cnt_i)
  );

  alpha_pkt_fifo #(.DEPTH(DEPTH)) u_fifo_d (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_d),
    .push_pkt (bus.d_req_pkt),
    .pop      (pop_d),
    .head_pkt (head_d),
    .full     (full_d),
    .empty    (empty_d),
    .count    (cnt_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      last_grant_q <= SRC_D;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
      live_q       <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (load) begin
        if (grant_i) begin
          out_q        <= head_i;
          last_grant_q <= SRC_I;
          i_cnt_q      <= i_cnt_q + 1'b1;
        end else begin
          out_q        <= head_d;
          last_grant_q <= SRC_D;
          d_cnt_q      <= d_cnt_q + 1'b1;
        end
      end else if (bus.mem_req_ack_xx) begin
        out_q <= '0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n)
                   (cnt_i <= CW'(DEPTH)) && (cnt_d <= CW'(DEPTH)));

  assign bus.i_req_rdy      = rdy_i;
  assign bus.d_req_rdy      = rdy_d;
  assign bus.mem_req_pkt_xx = out_q;
  assign bus.i_grant_cnt    = i_cnt_q;
  assign bus.d_grant_cnt    = d_cnt_q;

endmodule
